// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Shares one SRAM-like memory port between the instruction-fetch and the
// data (load/store) requesters. Address phases are arbitrated with fixed
// data-over-inst priority. A request that is presented but not yet accepted
// holds the port until it is accepted. Accepted transactions are tracked in an
// in-order tag FIFO so that each in-order memory response is routed back to
// the requester that issued it.
module mem_req_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 inst_req,
  input  logic [ADDR_W-1:0]                    inst_addr,
  output logic                                 inst_addr_ok,
  output logic                                 inst_data_ok,
  output logic [31:0]                          inst_rdata,
  input  logic                                 data_req,
  input  logic                                 data_wr,
  input  logic [1:0]                           data_size,
  input  logic [ADDR_W-1:0]                    data_addr,
  input  logic [31:0]                          data_wdata,
  output logic                                 data_addr_ok,
  output logic                                 data_data_ok,
  output logic [31:0]                          data_rdata,
  output logic                                 mem_req,
  output logic                                 mem_wr,
  output logic [1:0]                           mem_size,
  output logic [ADDR_W-1:0]                    mem_addr,
  output logic [31:0]                          mem_wdata,
  input  logic                                 mem_addr_ok,
  input  logic                                 mem_data_ok,
  input  logic [31:0]                          mem_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Source tags stored in the FIFO
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t                state_r;
  logic                       lock_src_r;
  logic [MAX_OUTSTANDING-1:0] tag_fifo_r;
  logic [PTR_W-1:0]           wr_ptr_r;
  logic [PTR_W-1:0]           rd_ptr_r;
  logic [CNT_W-1:0]           count_r;
  logic                       err_r;

  logic grant_src_s;
  logic grant_req_s;
  logic lock_drop_s;
  logic full_s;
  logic empty_s;
  logic mem_req_s;
  logic accept_s;
  logic pop_s;
  logic pop_tag_s;
  logic empty_pop_s;

  // Pick the granted source: priority arbitration when idle, locked source otherwise
  always_comb begin
    grant_src_s = SRC_INST;
    grant_req_s = 1'b0;
    lock_drop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (data_req) begin
          grant_src_s = SRC_DATA;
          grant_req_s = 1'b1;
        end else if (inst_req) begin
          grant_src_s = SRC_INST;
          grant_req_s = 1'b1;
        end else begin
          grant_src_s = SRC_INST;
          grant_req_s = 1'b0;
        end
      end
      ST_LOCKED: begin
        grant_src_s = lock_src_r;
        if (lock_src_r == SRC_DATA) begin
          grant_req_s = data_req;
        end else begin
          grant_req_s = inst_req;
        end
        // The locked requester withdrew before being accepted
        lock_drop_s = ~grant_req_s;
      end
      default: begin
        grant_src_s = SRC_INST;
        grant_req_s = 1'b0;
        lock_drop_s = 1'b0;
      end
    endcase
  end

  // Handshake qualifiers; everything is masked while reset is asserted
  always_comb begin
    full_s      = (count_r == MAX_CNT);
    empty_s     = (count_r == CNT_ZERO);
    mem_req_s   = ~reset & grant_req_s & ~full_s;
    accept_s    = mem_req_s & mem_addr_ok;
    pop_tag_s   = tag_fifo_r[rd_ptr_r];
    pop_s       = ~reset & mem_data_ok & ~empty_s;
    empty_pop_s = ~reset & mem_data_ok & empty_s;
  end

  // Drive the shared memory port from the granted source, zero when idle
  always_comb begin
    mem_req = mem_req_s;
    if (mem_req_s) begin
      if (grant_src_s == SRC_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = 1'b0;
        mem_size  = 2'd2;
        mem_addr  = inst_addr;
        mem_wdata = 32'd0;
      end
    end else begin
      mem_wr    = 1'b0;
      mem_size  = 2'd0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = 32'd0;
    end
  end

  // Address-phase acknowledges and response routing back to the requesters
  always_comb begin
    inst_addr_ok = accept_s & (grant_src_s == SRC_INST);
    data_addr_ok = accept_s & (grant_src_s == SRC_DATA);
    inst_data_ok = pop_s & (pop_tag_s == SRC_INST);
    data_data_ok = pop_s & (pop_tag_s == SRC_DATA);
    if (inst_data_ok) begin
      inst_rdata = mem_rdata;
    end else begin
      inst_rdata = 32'd0;
    end
    if (data_data_ok) begin
      data_rdata = mem_rdata;
    end else begin
      data_rdata = 32'd0;
    end
  end

  // Lock FSM: hold the port for a presented-but-unaccepted request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      lock_src_r <= SRC_INST;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_req_s && !mem_addr_ok) begin
            state_r    <= ST_LOCKED;
            lock_src_r <= grant_src_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (lock_drop_s || accept_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          lock_src_r <= SRC_INST;
        end
      endcase
    end
  end

  // In-order tag FIFO: push on accept, pop on a valid response
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_fifo_r <= {MAX_OUTSTANDING{1'b0}};
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
    end else begin
      if (accept_s) begin
        tag_fifo_r[wr_ptr_r] <= grant_src_s;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Occupancy counter; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= CNT_ZERO;
    end else begin
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky protocol error: withdrawn locked request or response with nothing outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (lock_drop_s || empty_pop_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign outstanding = count_r;
  assign err         = err_r;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester of the 5-stage pipeline.
- Sits between the IF/EXE-stage request logic and the memory-side bridge.
- Arbitrates address phases with fixed data-over-inst priority.
- Tracks outstanding transactions in an in-order tag FIFO and routes each data_ok/rdata back to the requester that issued it.

Parameters:
MAX_OUTSTANDING, 4, max accepted-but-unanswered transactions; power of 2, >= 2
ADDR_W, 32, address width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
inst_req  input  1  fetch request valid (read only)
inst_addr  input  ADDR_W  fetch address
inst_addr_ok  output  1  fetch address phase accepted
inst_data_ok  output  1  fetch response valid
inst_rdata  output  32  fetch read data
data_req  input  1  data request valid
data_wr  input  1  1 = store, 0 = load
data_size  input  2  0 = byte, 1 = half, 2 = word
data_addr  input  ADDR_W  data address
data_wdata  input  32  store data
data_addr_ok  output  1  data address phase accepted
data_data_ok  output  1  data response valid (load data or store ack)
data_rdata  output  32  load data
mem_req  output  1  shared port request
mem_wr  output  1  shared port write
mem_size  output  2  shared port size (inst always 2)
mem_addr  output  ADDR_W  shared port address
mem_wdata  output  32  shared port write data (inst: 0)
mem_addr_ok  input  1  memory accepted address phase
mem_data_ok  input  1  memory response valid (strictly in order)
mem_rdata  input  32  memory read data
outstanding  output  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy
err  output  1  sticky protocol error

Behaviour:
- Reset: FIFO empty, outstanding=0, lock cleared, err=0.
- Reset values of all outputs: every *_ok=0, mem_req=0, mem_wr=0, mem_size=0, mem_addr=0, mem_wdata=0, inst_rdata=0, data_rdata=0. The FIFO content is don't-care.
- Lock state machine, IDLE/LOCKED:
  - IDLE: grant = data if data_req, else inst if inst_req. mem_req=1 if any request and FIFO not full.
  - IDLE -> LOCKED when mem_req && !mem_addr_ok. The granted source is registered.
  - LOCKED: mem_* driven from the locked source regardless of the other requester. LOCKED -> IDLE on mem_addr_ok.
  - Requesters must hold req/addr/wdata stable until their addr_ok.
  - If the locked requester drops req, mem_req falls, the lock clears and err sets.
- Full: when outstanding == MAX_OUTSTANDING, mem_req=0 and both addr_ok=0. This takes priority over lock; lock is held.
- Accept: mem_req && mem_addr_ok.
  - The granted source's addr_ok=1 combinationally in the same cycle.
  - The source tag (0 = inst, 1 = data) is pushed into the FIFO at the clock edge.
- Response: mem_data_ok pops the FIFO head.
  - Tag 0 -> inst_data_ok=1, inst_rdata=mem_rdata. Tag 1 -> data_data_ok=1, data_rdata=mem_rdata.
  - Combinational, zero latency. The *_rdata outputs are 0 when not valid.
- Simultaneous push and pop: occupancy unchanged. A pop on a full FIFO frees space only from the next cycle; no same-cycle bypass.
- mem_data_ok with empty FIFO: ignored (no *_data_ok), err set.
- Same-cycle accept into an empty FIFO with mem_data_ok: treated as empty-pop error. A response can never return in its own accept cycle.
- Pointers wrap modulo MAX_OUTSTANDING. Occupancy counter is 0..MAX_OUTSTANDING.
- Reset mid-operation: all tracking is discarded. Late memory responses after reset set err and are dropped.
- err is sticky until reset.

Test Plan:
- Only inst_req, addr 0xBFC00000, mem_addr_ok=1 every cycle, mem_data_ok 2 cycles later with 0x3C08BFAF -> inst_addr_ok same cycle, inst_data_ok with inst_rdata=0x3C08BFAF, data_data_ok stays 0.
- inst_req and data_req (load, size 2, 0x80001000) same cycle -> data granted first. Next cycle inst granted. Responses 0x11111111 then 0x22222222 -> data_rdata=0x11111111 first, inst_rdata=0x22222222 second.
- inst_req with mem_addr_ok low 3 cycles, data_req rising in cycle 2 -> mem_addr stays 0xBFC00000 until accept (lock). Data accepted the following cycle.
- Issue 4 inst reads with no responses, MAX=4 -> outstanding=4, mem_req=0 on 5th. One mem_data_ok -> outstanding=3 next cycle, 5th request accepted then.
- Store size 0, addr 0x80000003, wdata 0xAB -> mem_wr=1, mem_size=0, mem_wdata=0xAB. Response -> data_data_ok=1.
- mem_data_ok with empty FIFO; separately, reset with 2 outstanding -> err=1, no *_data_ok, outstanding=0 after reset.
